// File: rtl/meter_ctrl.sv
// meter_ctrl: four-channel peak-level meter. Captures sound sample peaks,
// holds each new peak for a number of frames, then decays it one step per
// DECAY_FRAMES frames. Bars shown on s1..s4 only change at frame boundaries,
// which are derived by counting VGA line-start pulses.
module meter_ctrl #(
  parameter int unsigned LINES        = 525,
  parameter int unsigned HOLD_FRAMES  = 30,
  parameter int unsigned DECAY_FRAMES = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ena,
  input  logic       hline,
  input  logic       clear,
  input  logic       smp_valid,
  input  logic [1:0] smp_ch,
  input  logic [3:0] smp_lvl,
  output logic [3:0] s1,
  output logic [3:0] s2,
  output logic [3:0] s3,
  output logic [3:0] s4,
  output logic       frame_tick
);

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned LVL_W  = 4;
  localparam int unsigned HOLD_W = 6;
  localparam int unsigned LINE_W = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int unsigned PRE_W  = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;

  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINES - 1);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(DECAY_FRAMES - 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_FRAMES);

  // Frame timing
  logic [LINE_W-1:0] line_q, line_d;
  logic              ft_q, ft_d;
  logic              wrap_c;

  // Shared decay prescaler
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic              decay_step_c;

  // Per-channel peak / hold and the displayed bars
  logic [NUM_CH-1:0][LVL_W-1:0]  peak_q, peak_d, peak_dec_c;
  logic [NUM_CH-1:0][HOLD_W-1:0] hold_q, hold_d, hold_dec_c;
  logic [NUM_CH-1:0][LVL_W-1:0]  disp_q, disp_d;

  // Frame boundary: the hline that closes the last line of the frame.
  assign wrap_c = hline && (line_q == LINE_LAST);

  // Decay happens only in a frame_tick cycle where the prescaler rolls over.
  assign decay_step_c = ft_q && (pre_q == PRE_LAST);

  // Line counter and frame pulse; frame_tick is high for the one enabled
  // cycle following the wrap edge.
  always_comb begin
    line_d = line_q;
    ft_d   = ft_q;
    if (ena) begin
      if (hline) begin
        line_d = wrap_c ? '0 : line_q + LINE_W'(1);
      end
      ft_d = wrap_c;
    end
  end

  // Prescaler advances once per frame; clear realigns it to zero.
  always_comb begin
    pre_d = pre_q;
    if (ena) begin
      if (clear) begin
        pre_d = '0;
      end else if (ft_q) begin
        pre_d = decay_step_c ? '0 : pre_q + PRE_W'(1);
      end
    end
  end

  // Frame processing: run down hold, and once hold is exhausted decay peak.
  always_comb begin
    peak_dec_c = peak_q;
    hold_dec_c = hold_q;
    if (ft_q) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (hold_q[c] != '0) begin
          hold_dec_c[c] = hold_q[c] - HOLD_W'(1);
        end else if (decay_step_c && (peak_q[c] != '0)) begin
          peak_dec_c[c] = peak_q[c] - LVL_W'(1);
        end
      end
    end
  end

  // Sample capture against the already-decayed peak; clear drops the sample.
  always_comb begin
    peak_d = peak_q;
    hold_d = hold_q;
    if (ena) begin
      if (clear) begin
        peak_d = '0;
        hold_d = '0;
      end else begin
        peak_d = peak_dec_c;
        hold_d = hold_dec_c;
        if (smp_valid && (smp_lvl > peak_dec_c[smp_ch])) begin
          peak_d[smp_ch] = smp_lvl;
          hold_d[smp_ch] = HOLD_INIT;
        end
      end
    end
  end

  // Displayed bars latch the pre-edge peaks at the frame boundary only.
  always_comb begin
    disp_d = disp_q;
    if (ena) begin
      if (clear) begin
        disp_d = '0;
      end else if (wrap_c) begin
        disp_d = peak_q;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      line_q <= '0;
      ft_q   <= 1'b0;
      pre_q  <= '0;
      peak_q <= '0;
      hold_q <= '0;
      disp_q <= '0;
    end else begin
      line_q <= line_d;
      ft_q   <= ft_d;
      pre_q  <= pre_d;
      peak_q <= peak_d;
      hold_q <= hold_d;
      disp_q <= disp_d;
    end
  end

  assign s1         = disp_q[0];
  assign s2         = disp_q[1];
  assign s3         = disp_q[2];
  assign s4         = disp_q[3];
  assign frame_tick = ft_q;

endmodule

// File: doc/meter_ctrl.md
METER_CTRL -- requirements
Module: meter_ctrl

Interface
REQ-001 SHALL have parameter LINES, default 525, hline pulses per frame.
REQ-002 SHALL have parameter HOLD_FRAMES, default 30, range 1..63, frames a new peak is held before decay starts.
REQ-003 SHALL have parameter DECAY_FRAMES, default 4, range 1..15, frames per 1-step decay of a peak.
REQ-004 SHALL have port clock  in  1  sole clock, rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port ena  in  1  clock enable; all state holds when 0.
REQ-007 SHALL have port hline  in  1  one-cycle line-start pulse from the VGA timing block.
REQ-008 SHALL have port clear  in  1  synchronous zero of all peaks and hold counters.
REQ-009 SHALL have port smp_valid  in  1  sample strobe from the sound generator.
REQ-010 SHALL have port smp_ch  in  2  channel index 0..3 of the sample.
REQ-011 SHALL have port smp_lvl  in  4  sample level 0..15.
REQ-012 SHALL have ports s1, s2, s3, s4  out  4 each  displayed bar levels, channels 0..3, registered.
REQ-013 SHALL have port frame_tick  out  1  one-cycle pulse per frame, registered.

Function
REQ-014 All state SHALL update only on clock edges with ena=1; inputs SHALL be ignored when ena=0.
REQ-015 Line counter (0..LINES-1) SHALL increment on each hline and wrap from LINES-1 to 0.
REQ-016 On the edge where the line counter wraps, frame_tick SHALL go 1 for exactly one enabled cycle and s1..s4 SHALL load peak[0..3] as held before that edge.
REQ-017 s1..s4 SHALL change only on the wrap edge, clear, or reset; they SHALL never change mid-frame.
REQ-018 Per-channel state: peak (4 bit), hold (6 bit).
REQ-019 smp_valid with smp_lvl > peak[smp_ch] SHALL set peak to smp_lvl and hold to HOLD_FRAMES on the next edge.
REQ-020 smp_valid with smp_lvl <= peak[smp_ch] SHALL leave that channel unchanged.
REQ-021 Shared decay prescaler (0..DECAY_FRAMES-1) SHALL increment in every cycle with frame_tick=1 and wrap to 0; a wrap SHALL form decay_step.
REQ-022 In a cycle with frame_tick=1, each channel with hold>0 SHALL decrement hold.
REQ-023 In a cycle with decay_step, each channel with hold=0 and peak>0 SHALL decrement peak by 1; peak SHALL saturate at 0.
REQ-024 Sample in the same cycle as frame processing on the same channel: decayed value SHALL be computed first, then REQ-019 applied against the decayed value; the sample SHALL win when larger.
REQ-025 clear=1 SHALL zero all peaks, holds, s1..s4 and the prescaler; the line counter and frame_tick SHALL continue.
REQ-026 clear and smp_valid in the same cycle: clear SHALL take priority; the sample SHALL be dropped.
REQ-027 hline and frame_tick SHALL never require back-pressure; the block SHALL accept one sample per enabled cycle.

Reset
REQ-028 reset_n=0 SHALL immediately (asynchronously) set line counter, prescaler, all peaks, holds, s1..s4 and frame_tick to 0.
REQ-029 Release of reset_n SHALL resume counting from line 0 at the next hline; a frame in progress at assertion SHALL be discarded.

Verification
REQ-030 Reset, then 525 hline pulses (ena=1) -> frame_tick high exactly once, one cycle after the 525th hline edge; s1..s4 = 0.
REQ-031 Sample ch2 lvl 12 mid-frame -> s3 stays at old value until wrap, then s3=12; s1,s2,s4 unchanged.
REQ-032 Defaults, single sample ch0 lvl 9, then silence -> s1=9 for 30 frames after capture, then decrements 1 per 4 frames, reaching 0 and holding 0.
REQ-033 Sample ch1 lvl 5 in the frame_tick cycle while peak=8 and hold=0 with decay_step -> peak 7; same with lvl 10 -> peak 10, hold 30.
REQ-034 ena=0 for 1000 cycles with hline/smp_valid toggling -> no state or output change.
REQ-035 clear with smp_valid ch3 lvl 15 the same cycle -> all s and peaks 0, sample dropped; reset_n low mid-frame -> all outputs 0 without a clock edge.
